// File: rtl/fan_pkg.sv
// Shared types and widths for the fan speed sequencer.
package fan_pkg;

  localparam int SEL_W = 3;
  localparam int LED_W = 4;
  localparam int REM_W = 8;

  // Encodings double as the motor mux select value.
  typedef enum logic [SEL_W-1:0] {
    ST_OFF = 3'd0,
    ST_S1  = 3'd1,
    ST_S2  = 3'd2,
    ST_S3  = 3'd3,
    ST_S4  = 3'd4
  } fan_state_e;

  function automatic fan_state_e next_speed(input fan_state_e s);
    case (s)
      ST_S1:   return ST_S2;
      ST_S2:   return ST_S3;
      ST_S3:   return ST_S4;
      default: return ST_S1;
    endcase
  endfunction

  function automatic logic [LED_W-1:0] led_of(input fan_state_e s);
    case (s)
      ST_S1:   return 4'b0001;
      ST_S2:   return 4'b0011;
      ST_S3:   return 4'b0111;
      ST_S4:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/fan_tick_gen.sv
// Prescaler for the auto-off timer: one-cycle tick every DIV enabled cycles.
module fan_tick_gen #(
  parameter int DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_top;

  assign at_top = (cnt_q == CNT_W'(DIV - 1));
  assign tick   = enable && at_top;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || !enable || at_top) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fan_speed_ctrl.sv
// Fan speed sequencer: button edge detect, OFF/S1-S4 FSM, LED bar, and
// the optional auto-off countdown built when FAN_AUTO_OFF_TIMER_EN is defined.
module fan_speed_ctrl
  import fan_pkg::*;
#(
  parameter int TICK_DIV  = 100_000_000,
  parameter int TIMER_SEC = 60
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_btn_speed,
  input  logic             i_btn_off,
  input  logic             i_btn_timer,
  output logic [SEL_W-1:0] o_sel,
  output logic [LED_W-1:0] o_led,
  output logic             o_timer_on,
  output logic [REM_W-1:0] o_remain
);

  fan_state_e       state_q, state_d;
  logic [LED_W-1:0] led_q;
  logic             spd_q, off_q;
  logic             spd_evt, off_evt;

  assign spd_evt = i_btn_speed && !spd_q;
  assign off_evt = i_btn_off   && !off_q;

`ifdef FAN_AUTO_OFF_TIMER_EN
  logic             tmr_q, tmr_evt;
  logic             armed_q, armed_d;
  logic [REM_W-1:0] remain_q, remain_d;
  logic             tick, tmr_clr;

  assign tmr_evt = i_btn_timer && !tmr_q;

  fan_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk     (i_clk),
    .reset_n (i_reset_n),
    .clear   (tmr_clr),
    .enable  (armed_q),
    .tick    (tick)
  );

  // Priority: off, then expiry, then speed step, then timer toggle.
  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    remain_d = remain_q;
    tmr_clr  = 1'b0;
    if (off_evt) begin
      state_d  = ST_OFF;
      armed_d  = 1'b0;
      remain_d = '0;
    end else if (armed_q && tick && remain_q == REM_W'(1)) begin
      state_d  = ST_OFF;
      armed_d  = 1'b0;
      remain_d = '0;
    end else begin
      if (armed_q && tick) remain_d = remain_q - 1'b1;
      if (spd_evt) begin
        state_d = next_speed(state_q);
      end else if (tmr_evt && state_q != ST_OFF) begin
        tmr_clr = 1'b1;
        if (armed_q) begin
          armed_d  = 1'b0;
          remain_d = '0;
        end else begin
          armed_d  = 1'b1;
          remain_d = REM_W'(TIMER_SEC);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      tmr_q    <= 1'b0;
      armed_q  <= 1'b0;
      remain_q <= '0;
    end else begin
      tmr_q    <= i_btn_timer;
      armed_q  <= armed_d;
      remain_q <= remain_d;
    end
  end

  assign o_timer_on = armed_q;
  assign o_remain   = remain_q;
`else
  logic [2:0] unused_timer;
  assign unused_timer = {i_btn_timer, 1'(TICK_DIV % 2), 1'(TIMER_SEC % 2)};

  always_comb begin
    state_d = state_q;
    if (off_evt)      state_d = ST_OFF;
    else if (spd_evt) state_d = next_speed(state_q);
  end

  assign o_timer_on = 1'b0;
  assign o_remain   = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      spd_q   <= 1'b0;
      off_q   <= 1'b0;
      state_q <= ST_OFF;
      led_q   <= '0;
    end else begin
      spd_q   <= i_btn_speed;
      off_q   <= i_btn_off;
      state_q <= state_d;
      led_q   <= led_of(state_d);
    end
  end

  assign o_sel = state_q;
  assign o_led = led_q;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Directed bench for fan_speed_ctrl; timer checks follow FAN_AUTO_OFF_TIMER_EN.
module tb_fan_speed_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_speed = 1'b0;
  logic       btn_off = 1'b0;
  logic       btn_timer = 1'b0;
  logic [2:0] sel;
  logic [3:0] led;
  logic       timer_on;
  logic [7:0] remain;

  int checks = 0;
  int errors = 0;

  fan_speed_ctrl #(.TICK_DIV(10), .TIMER_SEC(3)) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_btn_speed (btn_speed),
    .i_btn_off   (btn_off),
    .i_btn_timer (btn_timer),
    .o_sel       (sel),
    .o_led       (led),
    .o_timer_on  (timer_on),
    .o_remain    (remain)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Press one button for one cycle: 0 speed, 1 off, 2 timer.
  task automatic press(input int which);
    case (which)
      0: btn_speed = 1'b1;
      1: btn_off   = 1'b1;
      default: btn_timer = 1'b1;
    endcase
    step();
    btn_speed = 1'b0;
    btn_off   = 1'b0;
    btn_timer = 1'b0;
  endtask

  int         exp_sel[5] = '{1, 2, 3, 4, 1};
  logic [3:0] exp_led[5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0001};

  initial begin
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    chk("rst_sel", sel, 0);
    chk("rst_led", led, 0);
    chk("rst_timer_on", timer_on, 0);
    chk("rst_remain", remain, 0);

    for (int i = 0; i < 5; i++) begin
      press(0);
      chk("seq_sel", sel, exp_sel[i]);
      chk("seq_led", led, exp_led[i]);
      step();
    end

    btn_speed = 1'b1;
    repeat (4) step();
    chk("held_sel", sel, 2);
    btn_speed = 1'b0;
    step();

    press(0);
    chk("to_s3", sel, 3);
    step();
    btn_off = 1'b1;
    press(0);
    chk("off_speed_sel", sel, 0);
    chk("off_speed_led", led, 0);
    step();
    press(2);
    chk("tmr_in_off", timer_on, 0);
    step();

`ifdef FAN_AUTO_OFF_TIMER_EN
    press(0); step();
    press(0); step();
    chk("pre_arm_sel", sel, 2);
    press(2);
    chk("arm_on", timer_on, 1);
    chk("arm_remain", remain, 3);
    chk("arm_sel", sel, 2);
    for (int k = 1; k <= 30; k++) begin
      btn_speed = (k == 14);
      step();
      if (k == 9)  chk("rem_t9", remain, 3);
      if (k == 10) chk("rem_t10", remain, 2);
      if (k == 15) begin
        chk("spd_t15_sel", sel, 3);
        chk("spd_t15_rem", remain, 2);
      end
      if (k == 19) chk("rem_t19", remain, 2);
      if (k == 20) chk("rem_t20", remain, 1);
      if (k == 29) begin
        chk("t29_rem", remain, 1);
        chk("t29_on", timer_on, 1);
        chk("t29_sel", sel, 3);
      end
      if (k == 30) begin
        chk("exp_sel", sel, 0);
        chk("exp_led", led, 0);
        chk("exp_on", timer_on, 0);
        chk("exp_rem", remain, 0);
      end
    end
    btn_speed = 1'b0;
    step();

    press(0);
    chk("s1_sel", sel, 1);
    step();
    press(2);
    chk("rearm_on", timer_on, 1);
    repeat (4) step();
    press(2);
    chk("disarm_on", timer_on, 0);
    chk("disarm_rem", remain, 0);
    chk("disarm_sel", sel, 1);
    repeat (40) step();
    chk("no_expiry_sel", sel, 1);

    press(2);
    repeat (12) step();
    chk("mid_rem", remain, 2);
    reset_n = 1'b0;
    step();
    chk("midrst_sel", sel, 0);
    chk("midrst_led", led, 0);
    chk("midrst_on", timer_on, 0);
    chk("midrst_rem", remain, 0);
    reset_n = 1'b1;
    step();
`else
    press(0);
    chk("s1_sel", sel, 1);
    step();
    press(2);
    repeat (100) step();
    chk("notmr_sel", sel, 1);
    chk("notmr_on", timer_on, 0);
    chk("notmr_rem", remain, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
